// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - shared geometry constants and scheduler state encoding
package block_pkg;

    localparam int BLK_ROWS  = 16;
    localparam int BLK_COLS  = 13;
    localparam int LINE_W    = BLK_COLS;
    localparam int ROW_W     = 4;
    localparam int COL_W     = 4;
    localparam int BLK_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEEK,
        ST_SERVE
    } sched_state_t;

endpackage

// File: rtl/popcount13.sv
// rtl/popcount13.sv - combinational ones count of one block line
module popcount13
    import block_pkg::*;
(
    input  logic [LINE_W-1:0] bits,
    output logic [3:0]        count
);

    // Sum the set bits of the line.
    always_comb begin
        count = '0;
        for (int i = 0; i < LINE_W; i++) begin
            count = count + {3'b000, bits[i]};
        end
    end

endmodule

// File: rtl/block_line_sched.sv
// rtl/block_line_sched.sv - arbitrates video and collision access to a rotating block line store
module block_line_sched
    import block_pkg::*;
#(
    parameter int ROWS = BLK_ROWS,
    parameter int COLS = BLK_COLS
)
(
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [COLS-1:0]      line_in,
    output logic                 next_line,
    output logic                 line_we,
    output logic [COLS-1:0]      line_wdata,
    input  logic                 vid_req,
    input  logic [ROW_W-1:0]     vid_row,
    output logic                 vid_ack,
    output logic [COLS-1:0]      vid_line,
    input  logic                 col_req,
    input  logic [ROW_W-1:0]     col_row,
    input  logic [COL_W-1:0]     col_col,
    input  logic                 col_clear,
    output logic                 col_ack,
    output logic                 col_hit,
    output logic [ROW_W-1:0]     head_row,
    output logic [BLK_CNT_W-1:0] blocks_left,
    output logic                 init_done,
    output logic                 all_clear
);

    sched_state_t         state;
    logic [ROW_W-1:0]     tgt_row;
    logic [COL_W-1:0]     tgt_col;
    logic                 tgt_clear;
    logic                 gnt_vid;
    logic                 rr_col_first;
    logic [ROW_W-1:0]     init_cnt;
    logic [BLK_CNT_W-1:0] acc;
    logic [3:0]           pop;
    logic [COLS-1:0]      vid_line_q;
    logic                 col_hit_q;
    logic [COLS-1:0]      col_mask;
    logic                 hit_now;
    logic                 clear_now;
    logic                 pick_vid;
    logic                 any_req;
    logic [ROW_W-1:0]     sel_row;
    logic [ROW_W-1:0]     next_head;

    popcount13 u_pop (
        .bits  (line_in),
        .count (pop)
    );

    // Request selection: on contention the pointer decides; a lone requester always wins.
    always_comb begin
        any_req   = vid_req | col_req;
        pick_vid  = vid_req && (!col_req || !rr_col_first);
        sel_row   = pick_vid ? vid_row : col_row;
        next_head = (head_row == ROW_W'(ROWS - 1)) ? '0 : head_row + 1'b1;
    end

    // Column c addresses line bit COLS-1-c; out-of-range columns select nothing.
    always_comb begin
        col_mask = '0;
        if (tgt_col < COL_W'(COLS)) begin
            col_mask[COL_W'(COLS - 1) - tgt_col] = 1'b1;
        end
        hit_now    = |(line_in & col_mask);
        clear_now  = col_ack && tgt_clear && hit_now;
        line_we    = clear_now;
        line_wdata = line_in & ~col_mask;
        vid_line   = vid_ack ? line_in : vid_line_q;
        col_hit    = col_ack ? hit_now : col_hit_q;
        all_clear  = init_done && (blocks_left == '0);
    end

    // Scheduler FSM: census the store, then seek and serve one request at a time.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= ST_INIT;
            head_row     <= '0;
            blocks_left  <= '0;
            init_done    <= 1'b0;
            next_line    <= 1'b0;
            vid_ack      <= 1'b0;
            col_ack      <= 1'b0;
            tgt_row      <= '0;
            tgt_col      <= '0;
            tgt_clear    <= 1'b0;
            gnt_vid      <= 1'b0;
            rr_col_first <= 1'b0;
            init_cnt     <= '0;
            acc          <= '0;
            vid_line_q   <= '0;
            col_hit_q    <= 1'b0;
        end else begin
            if (next_line) begin
                head_row <= next_head;
            end
            case (state)
                ST_INIT: begin
                    if (!next_line) begin
                        next_line <= 1'b1;
                    end else begin
                        acc <= acc + BLK_CNT_W'(pop);
                        if (init_cnt == ROW_W'(ROWS - 1)) begin
                            next_line   <= 1'b0;
                            blocks_left <= acc + BLK_CNT_W'(pop);
                            init_done   <= 1'b1;
                            init_cnt    <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            init_cnt <= init_cnt + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_vid   <= pick_vid;
                        tgt_row   <= sel_row;
                        tgt_col   <= col_col;
                        tgt_clear <= col_clear & ~pick_vid;
                        // The pointer only moves when both sides actually competed.
                        if (vid_req && col_req) begin
                            rr_col_first <= pick_vid;
                        end
                        if (sel_row == head_row) begin
                            vid_ack <= pick_vid;
                            col_ack <= !pick_vid;
                            state   <= ST_SERVE;
                        end else begin
                            next_line <= 1'b1;
                            state     <= ST_SEEK;
                        end
                    end
                end
                ST_SEEK: begin
                    // Stop rotating on the pulse that brings the target row to the head.
                    if (next_head == tgt_row) begin
                        next_line <= 1'b0;
                        vid_ack   <= gnt_vid;
                        col_ack   <= !gnt_vid;
                        state     <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    vid_ack <= 1'b0;
                    col_ack <= 1'b0;
                    state   <= ST_IDLE;
                    if (vid_ack) begin
                        vid_line_q <= line_in;
                    end
                    if (col_ack) begin
                        col_hit_q <= hit_now;
                    end
                    if (clear_now && (blocks_left != '0)) begin
                        blocks_left <= blocks_left - 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_line_sched.sv
// tb/tb_block_line_sched.sv - scoreboard bench for the block line scheduler
`timescale 1ns/1ps
module tb_block_line_sched;
    import block_pkg::*;

    localparam logic [12:0] R0      = 13'b0101010101111;
    localparam logic [12:0] R0_CLR  = 13'b0101010101110;
    localparam logic [12:0] R5      = 13'b1010101011010;
    localparam logic [12:0] P7      = 13'b1111111000000;
    localparam logic [12:0] P7_CLR6 = 13'b1111110000000;
    localparam logic [12:0] P6      = 13'b0000000111111;

    typedef struct {
        bit          is_vid;
        logic [12:0] line;
        bit          hit;
        bit          we;
        logic [12:0] wdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [12:0] line_in;
    logic        next_line, line_we;
    logic [12:0] line_wdata;
    logic        vid_req = 1'b0;
    logic [3:0]  vid_row = '0;
    logic        vid_ack;
    logic [12:0] vid_line;
    logic        col_req = 1'b0;
    logic [3:0]  col_row = '0;
    logic [3:0]  col_col = '0;
    logic        col_clear = 1'b0;
    logic        col_ack, col_hit;
    logic [3:0]  head_row;
    logic [7:0]  blocks_left;
    logic        init_done, all_clear;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nl_cnt = 0;
    int          k;

    logic [12:0] store [16];
    logic [3:0]  ptr;

    block_line_sched dut (
        .clk         (clk),
        .nRst        (nRst),
        .line_in     (line_in),
        .next_line   (next_line),
        .line_we     (line_we),
        .line_wdata  (line_wdata),
        .vid_req     (vid_req),
        .vid_row     (vid_row),
        .vid_ack     (vid_ack),
        .vid_line    (vid_line),
        .col_req     (col_req),
        .col_row     (col_row),
        .col_col     (col_col),
        .col_clear   (col_clear),
        .col_ack     (col_ack),
        .col_hit     (col_hit),
        .head_row    (head_row),
        .blocks_left (blocks_left),
        .init_done   (init_done),
        .all_clear   (all_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] init_row(input int r);
        if (r == 0) return R0;
        if (r == 5) return R5;
        if (r <= 6) return P7;
        return P6;
    endfunction

    // Rotating line store: head row on line_in, rotate on next_line, overwrite on line_we.
    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < 16; i++) store[i] <= init_row(i);
            ptr <= '0;
        end else begin
            if (line_we) store[ptr] <= line_wdata;
            if (next_line) ptr <= ptr + 4'd1;
        end
    end
    assign line_in = store[ptr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit v, input logic [12:0] ln, input bit h, input bit w,
                        input logic [12:0] wd, input int c);
        exp_t e;
        e.is_vid = v; e.line = ln; e.hit = h; e.we = w; e.wdata = wd; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic request(input bit is_vid, input logic [3:0] row, input logic [3:0] col,
                           input bit clr);
        bit got = 1'b0;
        if (is_vid) begin
            vid_row = row; vid_req = 1'b1;
        end else begin
            col_row = row; col_col = col; col_clear = clr; col_req = 1'b1;
        end
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (is_vid ? vid_ack : col_ack) got = 1'b1;
        end
        if (is_vid) vid_req = 1'b0;
        else col_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout requester=%s actual=no_ack expected=ack", is_vid ? "vid" : "col");
        end
    endtask

    task automatic wait_init();
        for (int n = 0; n < 64 && !init_done; n++) tick();
        chk("init_done_timeout", 32'(init_done), 32'd1);
    endtask

    // Monitor: pop and compare on every ack, and watch for write/rotate overlap.
    always @(negedge clk) begin
        if (nRst) begin
            if (next_line) nl_cnt++;
            chk("we_nl_overlap", 32'(line_we && next_line), 32'd0);
            if (vid_ack || col_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual vid_ack=%0b col_ack=%0b expected none", vid_ack, col_ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_kind", 32'({vid_ack, col_ack}), mon_e.is_vid ? 32'd2 : 32'd1);
                    chk("ack_latency", 32'(cyc), 32'(mon_e.cyc));
                    chk("ack_next_line", 32'(next_line), 32'd0);
                    if (mon_e.is_vid) begin
                        chk("vid_line", 32'(vid_line), 32'(mon_e.line));
                        chk("vid_no_we", 32'(line_we), 32'd0);
                    end else begin
                        chk("col_hit", 32'(col_hit), 32'(mon_e.hit));
                        chk("line_we", 32'(line_we), 32'(mon_e.we));
                        if (mon_e.we) chk("line_wdata", 32'(line_wdata), 32'(mon_e.wdata));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_head_row", 32'(head_row), 32'd0);
        chk("rst_blocks_left", 32'(blocks_left), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_next_line", 32'(next_line), 32'd0);
        chk("rst_line_we", 32'(line_we), 32'd0);
        chk("rst_acks", 32'({vid_ack, col_ack}), 32'd0);
        chk("rst_vid_line", 32'(vid_line), 32'd0);
        chk("rst_col_hit", 32'(col_hit), 32'd0);
        chk("rst_all_clear", 32'(all_clear), 32'd0);

        tick();
        nl_cnt = 0;
        nRst = 1'b1;
        wait_init();
        chk("init_pulses", 32'(nl_cnt), 32'd16);
        chk("init_blocks", 32'(blocks_left), 32'd104);
        chk("init_head", 32'(head_row), 32'd0);
        chk("init_all_clear", 32'(all_clear), 32'd0);

        // Video row 5 from head 0: d=5.
        nl_cnt = 0; k = cyc;
        push(1'b1, R5, 1'b0, 1'b0, '0, k + 6);
        request(1'b1, 4'd5, 4'd0, 1'b0);
        tick();
        chk("vid5_pulses", 32'(nl_cnt), 32'd5);
        chk("vid5_head", 32'(head_row), 32'd5);
        chk("vid5_hold", 32'(vid_line), 32'(R5));

        // Clear row 0 col 12 from head 5: d=11.
        nl_cnt = 0; k = cyc;
        push(1'b0, '0, 1'b1, 1'b1, R0_CLR, k + 12);
        request(1'b0, 4'd0, 4'd12, 1'b1);
        tick();
        chk("clr_pulses", 32'(nl_cnt), 32'd11);
        chk("clr_blocks", 32'(blocks_left), 32'd103);
        chk("clr_head", 32'(head_row), 32'd0);
        chk("clr_hit_hold", 32'(col_hit), 32'd1);

        // Out-of-range column, then repeat clear of an already-empty bit.
        k = cyc;
        push(1'b0, '0, 1'b0, 1'b0, '0, k + 1);
        request(1'b0, 4'd0, 4'd13, 1'b1);
        tick();
        chk("col13_blocks", 32'(blocks_left), 32'd103);
        chk("col13_hit_hold", 32'(col_hit), 32'd0);
        k = cyc;
        push(1'b0, '0, 1'b0, 1'b0, '0, k + 1);
        request(1'b0, 4'd0, 4'd12, 1'b1);
        tick();
        chk("reclr_blocks", 32'(blocks_left), 32'd103);

        // Probe without clear: row 0 col 1 is set.
        k = cyc;
        push(1'b0, '0, 1'b1, 1'b0, '0, k + 1);
        request(1'b0, 4'd0, 4'd1, 1'b0);
        tick();
        chk("probe_blocks", 32'(blocks_left), 32'd103);

        // First contended pair: video wins, then collision.
        k = cyc;
        push(1'b1, P7, 1'b0, 1'b0, '0, k + 3);
        push(1'b0, '0, 1'b1, 1'b0, '0, k + 6);
        fork
            request(1'b1, 4'd2, 4'd0, 1'b0);
            request(1'b0, 4'd3, 4'd0, 1'b0);
        join
        tick();
        chk("pair1_head", 32'(head_row), 32'd3);
        chk("pair1_vid_hold", 32'(vid_line), 32'(P7));

        // Second contended pair: collision wins, then video.
        k = cyc;
        push(1'b0, '0, 1'b1, 1'b1, P7_CLR6, k + 1);
        push(1'b1, P6, 1'b0, 1'b0, '0, k + 7);
        fork
            request(1'b1, 4'd7, 4'd0, 1'b0);
            request(1'b0, 4'd3, 4'd6, 1'b1);
        join
        tick();
        chk("pair2_blocks", 32'(blocks_left), 32'd102);
        chk("pair2_head", 32'(head_row), 32'd7);

        // Video at distance zero.
        k = cyc;
        push(1'b1, P6, 1'b0, 1'b0, '0, k + 1);
        request(1'b1, 4'd7, 4'd0, 1'b0);
        tick();

        // Reset during a d=10 seek: no ack, INIT re-runs.
        col_row = 4'd1; col_col = 4'd0; col_clear = 1'b1; col_req = 1'b1;
        repeat (5) tick();
        chk("seek_rotating", 32'(next_line), 32'd1);
        nRst = 1'b0;
        col_req = 1'b0;
        #1;
        chk("midrst_next_line", 32'(next_line), 32'd0);
        chk("midrst_head", 32'(head_row), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        tick();
        nl_cnt = 0;
        nRst = 1'b1;
        wait_init();
        chk("reinit_pulses", 32'(nl_cnt), 32'd16);
        chk("reinit_blocks", 32'(blocks_left), 32'd104);
        chk("reinit_head", 32'(head_row), 32'd0);
        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
